screen_text_writer: RTL and testbench
=====================================

Name: screen_text_writer

Overview:
- Upstream producer for the character screen memory read by the VGA display driver.
- Accepts a stream of character codes and cursor commands over a valid/ready handshake.
- Tracks a text cursor and issues single-cycle writes (address, data) into the 40x30 screen memory's write port.
- Provides a multi-cycle clear-screen sequence that fills every cell with the blank code.

Parameters:
- COLS, 40, characters per row (640/16).
- ROWS, 30, character rows (480/16).
- SM_LEN, 11, screen memory address width; COLS*ROWS must be <= 2**SM_LEN.
- ALPHABET_LEN, 5, character code width.
- ALPHABET_SIZE, 27, number of valid codes (0..ALPHABET_SIZE-1).
- BLANK_CODE, 0, code written by clear and substituted for invalid codes.

Ports:
- clock  input  1  system clock (CLOCK_50 domain)
- reset_n  input  1  asynchronous active-low reset
- in_valid  input  1  command/char present
- in_ready  output  1  block can accept this cycle
- in_cmd  input  2  00 CHAR, 01 NEWLINE, 10 CLEAR, 11 HOME
- in_char  input  ALPHABET_LEN  character code, used only for CHAR
- wr_en  output  1  screen memory write strobe
- wr_addr  output  SM_LEN  screen memory write address
- wr_data  output  ALPHABET_LEN  screen memory write data
- cursor_col  output  $clog2(COLS)  current cursor column
- cursor_row  output  $clog2(ROWS)  current cursor row
- busy  output  1  clear sequence in progress

Behaviour:
- Reset (async, immediate):
  - wr_en=0, wr_addr=0, wr_data=BLANK_CODE, cursor=(0,0), busy=0, state=IDLE.
  - in_ready=1 once reset_n deasserts.
- State machine: IDLE, CLEAR.
  - in_ready = (state==IDLE), combinational.
  - Accept occurs at a rising edge with in_valid && in_ready.
- Output timing: wr_en, wr_addr and wr_data are registered.
  - wr_en is high exactly one cycle per write.
  - A write issued for an accept at edge N is visible after edge N and sampled by memory at edge N+1.
- CHAR:
  - wr_addr = cursor_row*COLS + cursor_col, computed in SM_LEN bits.
  - wr_data = in_char if in_char < ALPHABET_SIZE, else BLANK_CODE.
  - Cursor advances col+1.
  - At col==COLS-1: col=0, row+1.
  - At row==ROWS-1 also: row=0 (wrap to top, no scroll).
  - Throughput is one char per cycle; in_ready stays 1 back-to-back.
- NEWLINE: col=0, row+1 with the same row wrap; no write.
- HOME: cursor=(0,0); no write.
- CLEAR:
  - Next state is CLEAR: busy=1, in_ready=0.
  - Writes BLANK_CODE to addresses 0..COLS*ROWS-1, one per cycle, in ascending order with no gaps.
  - After the final write (addr COLS*ROWS-1): cursor=(0,0), busy=0, state=IDLE.
  - in_ready returns 1 exactly COLS*ROWS cycles after the accept.
- Inputs during CLEAR are ignored (in_ready=0); the source must hold them.
- Reset mid-clear:
  - Abort immediately; no further writes.
  - Memory is left partially cleared; the clear is not resumed.
- Counter widths: the clear address counter is SM_LEN bits and never exceeds COLS*ROWS-1.

Optional Feature:
- Macro: SCREEN_TEXT_WRITER_WRAP_CLEAR_EN
- Defined: a CHAR write at cell (COLS-1, ROWS-1) performs its write, then enters CLEAR automatically on the following cycle.
  - busy=1 and in_ready=0 for COLS*ROWS cycles; cursor ends at (0,0).
- Undefined: the cursor wraps to (0,0) silently and existing text is overwritten.

Test Plan:
- Reset, then CHAR in_char=5 -> one cycle later wr_en=1, wr_addr=0, wr_data=5; cursor=(1,0); wr_en=0 the following cycle.
- 41 CHARs back-to-back, codes 1..41 mod 27 -> wr_addr 0..40 on consecutive cycles; in_ready stays 1; final cursor=(1,1).
- Cursor (10,2), NEWLINE -> no wr_en; cursor=(0,3); next CHAR in_char=26 -> wr_addr=120, wr_data=26. CHAR in_char=30 -> wr_data=0.
- CLEAR accepted -> in_ready=0 and busy=1 for 1200 cycles; wr_addr 0..1199, all wr_data=0; then in_ready=1, cursor=(0,0).
- Cursor (39,29), CHAR in_char=7 -> wr_addr=1199, cursor=(0,0).
  - With macro: a 1200-cycle clear follows.
  - Without macro: in_ready stays 1.
- reset_n low while clearing at wr_addr=600 -> wr_en=0 immediately, busy=0; after release in_ready=1, cursor=(0,0), no writes.

Source files
------------

// File: rtl/screen_text_writer_if.sv
// screen_text_writer_if: command handshake and screen memory write port
interface screen_text_writer_if #(
    parameter int SM_LEN       = 11,
    parameter int ALPHABET_LEN = 5
);
    logic                    in_valid;
    logic                    in_ready;
    logic [1:0]              in_cmd;
    logic [ALPHABET_LEN-1:0] in_char;
    logic                    wr_en;
    logic [SM_LEN-1:0]       wr_addr;
    logic [ALPHABET_LEN-1:0] wr_data;

    modport master (
        output in_valid, in_cmd, in_char,
        input  in_ready, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  in_valid, in_cmd, in_char,
        output in_ready, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/screen_text_writer.sv
// screen_text_writer: cursor-tracking character writer with clear-screen sequencer.
// Optional: SCREEN_TEXT_WRITER_WRAP_CLEAR_EN clears the screen after writing the last cell.
module screen_text_writer #(
    parameter int COLS          = 40,
    parameter int ROWS          = 30,
    parameter int SM_LEN        = 11,
    parameter int ALPHABET_LEN  = 5,
    parameter int ALPHABET_SIZE = 27,
    parameter int BLANK_CODE    = 0
) (
    input  logic                     clock,
    input  logic                     reset_n,
    screen_text_writer_if.slave      bus,
    output logic [$clog2(COLS)-1:0]  cursor_col,
    output logic [$clog2(ROWS)-1:0]  cursor_row,
    output logic                     busy
);
    localparam int CW = $clog2(COLS);
    localparam int RW = $clog2(ROWS);
    localparam logic [SM_LEN-1:0]       LAST_ADDR = SM_LEN'(COLS*ROWS-1);
    localparam logic [ALPHABET_LEN-1:0] BLANK     = ALPHABET_LEN'(BLANK_CODE);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           col_q, col_d;
    logic [RW-1:0]           row_q, row_d;
    logic [SM_LEN-1:0]       clr_q, clr_d;
    logic                    wr_en_q, wr_en_d;
    logic [SM_LEN-1:0]       wr_addr_q, wr_addr_d;
    logic [ALPHABET_LEN-1:0] wr_data_q, wr_data_d;
    logic                    last_col, last_row, char_ok;
    logic [RW-1:0]           row_nx;
    logic [SM_LEN-1:0]       cell_addr;

    assign last_col  = col_q == CW'(COLS-1);
    assign last_row  = row_q == RW'(ROWS-1);
    assign row_nx    = last_row ? '0 : row_q + 1'b1;
    assign cell_addr = SM_LEN'(row_q) * SM_LEN'(COLS) + SM_LEN'(col_q);
    assign char_ok   = {1'b0, bus.in_char} < (ALPHABET_LEN+1)'(ALPHABET_SIZE);

    assign bus.in_ready = state_q == IDLE;
    assign busy         = state_q == CLEAR;
    assign bus.wr_en    = wr_en_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;
    assign cursor_col   = col_q;
    assign cursor_row   = row_q;

    // Next state: sweep clear addresses while clearing, otherwise execute the accepted command
    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        row_d     = row_q;
        clr_d     = clr_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (state_q == CLEAR) begin
            wr_en_d   = 1'b1;
            wr_addr_d = clr_q;
            wr_data_d = BLANK;
            clr_d     = clr_q + 1'b1;
            if (clr_q == LAST_ADDR) begin
                state_d = IDLE;
                clr_d   = '0;
                col_d   = '0;
                row_d   = '0;
            end
        end else if (bus.in_valid) begin
            case (bus.in_cmd)
                2'b00: begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = cell_addr;
                    wr_data_d = char_ok ? bus.in_char : BLANK;
                    col_d     = last_col ? '0 : col_q + 1'b1;
                    row_d     = last_col ? row_nx : row_q;
`ifdef SCREEN_TEXT_WRITER_WRAP_CLEAR_EN
                    if (last_col && last_row) begin
                        state_d = CLEAR;
                        clr_d   = '0;
                    end
`endif
                end
                2'b01: begin
                    col_d = '0;
                    row_d = row_nx;
                end
                2'b10: begin
                    state_d = CLEAR;
                    clr_d   = '0;
                end
                default: begin
                    col_d = '0;
                    row_d = '0;
                end
            endcase
        end
    end

    // State registers; async reset aborts any clear in progress
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            col_q     <= '0;
            row_q     <= '0;
            clr_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= BLANK;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            row_q     <= row_d;
            clr_q     <= clr_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end
endmodule

// File: tb/tb_screen_text_writer.sv
// tb_screen_text_writer: vector table plus scoreboard of expected memory writes
module tb_screen_text_writer;
    localparam int COLS  = 40;
    localparam int ROWS  = 30;
    localparam int CELLS = COLS * ROWS;

    typedef struct {
        int addr;
        int data;
    } wr_t;

    typedef struct {
        logic [1:0] cmd;
        logic [4:0] ch;
        int         col;
        int         row;
        logic       wr;
    } vec_t;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [5:0] cursor_col;
    logic [4:0] cursor_row;
    logic       busy;
    int         checks = 0;
    int         errors = 0;
    int         mcol = 0;
    int         mrow = 0;
    wr_t        sb[$];

    screen_text_writer_if #(.SM_LEN(11), .ALPHABET_LEN(5)) bus ();

    screen_text_writer dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .bus        (bus.slave),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Every write the DUT shows must be the next one the model predicted
    always @(negedge clock) begin
        if (reset_n && bus.wr_en) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %0d data %0d expected no write", bus.wr_addr, bus.wr_data);
            end else begin
                wr_t e;
                e = sb.pop_front();
                chk("sb_addr", 32'(bus.wr_addr), e.addr);
                chk("sb_data", 32'(bus.wr_data), e.data);
            end
        end
    end

    task automatic push_clear();
        for (int k = 0; k < CELLS; k++) sb.push_back('{k, 0});
        mcol = 0;
        mrow = 0;
    endtask

    task automatic send(input logic [1:0] cmd, input logic [4:0] ch);
        chk("in_ready_before_accept", bus.in_ready, 1);
        bus.in_valid = 1'b1;
        bus.in_cmd   = cmd;
        bus.in_char  = ch;
        case (cmd)
            2'b00: begin
                bit last;
                last = (mcol == COLS-1) && (mrow == ROWS-1);
                sb.push_back('{mrow*COLS + mcol, (ch < 27) ? int'(ch) : 0});
                if (mcol == COLS-1) begin
                    mcol = 0;
                    mrow = (mrow + 1) % ROWS;
                end else mcol++;
`ifdef SCREEN_TEXT_WRITER_WRAP_CLEAR_EN
                if (last) push_clear();
`endif
            end
            2'b01: begin
                mcol = 0;
                mrow = (mrow + 1) % ROWS;
            end
            2'b10: push_clear();
            default: begin
                mcol = 0;
                mrow = 0;
            end
        endcase
        @(posedge clock);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_clear(input string name);
        int n;
        n = 0;
        chk({name, "_busy"}, busy, 1);
        chk({name, "_ready_low"}, bus.in_ready, 0);
        while (!bus.in_ready && n < 2000) begin
            @(posedge clock);
            #1;
            n++;
        end
        chk({name, "_cycles"}, n, CELLS);
        chk({name, "_busy_done"}, busy, 0);
        chk({name, "_col"}, cursor_col, 0);
        chk({name, "_row"}, cursor_row, 0);
    endtask

    initial begin
        vec_t vt[10];
        int   n;
        vt[0] = '{2'b11, 5'd0,  0, 0, 1'b0};
        vt[1] = '{2'b00, 5'd5,  1, 0, 1'b1};
        vt[2] = '{2'b00, 5'd30, 2, 0, 1'b1};
        vt[3] = '{2'b00, 5'd26, 3, 0, 1'b1};
        vt[4] = '{2'b01, 5'd9,  0, 1, 1'b0};
        vt[5] = '{2'b00, 5'd27, 1, 1, 1'b1};
        vt[6] = '{2'b00, 5'd31, 2, 1, 1'b1};
        vt[7] = '{2'b01, 5'd0,  0, 2, 1'b0};
        vt[8] = '{2'b00, 5'd1,  1, 2, 1'b1};
        vt[9] = '{2'b11, 5'd3,  0, 0, 1'b0};
        bus.in_valid = 1'b0;
        bus.in_cmd   = 2'b00;
        bus.in_char  = '0;
        #1;
        chk("rst_wr_en", bus.wr_en, 0);
        chk("rst_wr_addr", bus.wr_addr, 0);
        chk("rst_wr_data", bus.wr_data, 0);
        chk("rst_col", cursor_col, 0);
        chk("rst_row", cursor_row, 0);
        chk("rst_busy", busy, 0);
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        #1;
        chk("rst_ready", bus.in_ready, 1);

        // First write latency and single-cycle strobe
        send(2'b00, 5'd5);
        chk("first_wr_en", bus.wr_en, 1);
        chk("first_wr_addr", bus.wr_addr, 0);
        chk("first_wr_data", bus.wr_data, 5);
        chk("first_col", cursor_col, 1);
        chk("first_row", cursor_row, 0);
        @(posedge clock);
        #1;
        chk("first_wr_en_drop", bus.wr_en, 0);

        for (int i = 0; i < 10; i++) begin
            send(vt[i].cmd, vt[i].ch);
            chk($sformatf("vec%0d_wr_en", i), bus.wr_en, vt[i].wr);
            chk($sformatf("vec%0d_col", i), cursor_col, vt[i].col);
            chk($sformatf("vec%0d_row", i), cursor_row, vt[i].row);
        end

        // 41 back-to-back characters across the first row boundary
        for (int i = 1; i <= 41; i++) begin
            send(2'b00, 5'(i % 27));
            chk("b2b_addr", bus.wr_addr, i - 1);
        end
        chk("b2b_col", cursor_col, 1);
        chk("b2b_row", cursor_row, 1);

        // Newline from (10,2), then valid and invalid codes
        send(2'b11, 5'd0);
        send(2'b01, 5'd0);
        send(2'b01, 5'd0);
        for (int i = 0; i < 10; i++) send(2'b00, 5'd1);
        @(posedge clock);
        #1;
        send(2'b01, 5'd0);
        chk("nl_wr_en", bus.wr_en, 0);
        chk("nl_col", cursor_col, 0);
        chk("nl_row", cursor_row, 3);
        send(2'b00, 5'd26);
        chk("nl_char_addr", bus.wr_addr, 120);
        chk("nl_char_data", bus.wr_data, 26);
        send(2'b00, 5'd30);
        chk("bad_char_data", bus.wr_data, 0);

        send(2'b10, 5'd0);
        wait_clear("clear");

        // Last cell write and wrap
        send(2'b11, 5'd0);
        for (int i = 0; i < ROWS-1; i++) send(2'b01, 5'd0);
        for (int i = 0; i < COLS-1; i++) send(2'b00, 5'd2);
        chk("pre_wrap_col", cursor_col, 39);
        chk("pre_wrap_row", cursor_row, 29);
        send(2'b00, 5'd7);
        chk("wrap_addr", bus.wr_addr, 1199);
        chk("wrap_data", bus.wr_data, 7);
        chk("wrap_col", cursor_col, 0);
        chk("wrap_row", cursor_row, 0);
`ifdef SCREEN_TEXT_WRITER_WRAP_CLEAR_EN
        wait_clear("wrap_clear");
`else
        chk("wrap_ready", bus.in_ready, 1);
        chk("wrap_busy", busy, 0);
`endif

        // Reset in the middle of a clear
        send(2'b10, 5'd0);
        n = 0;
        while (!(bus.wr_en && bus.wr_addr == 11'd600) && n < 2000) begin
            @(posedge clock);
            #1;
            n++;
        end
        chk("abort_reached_600", n < 2000, 1);
        reset_n = 1'b0;
        #1;
        sb.delete();
        mcol = 0;
        mrow = 0;
        chk("abort_wr_en", bus.wr_en, 0);
        chk("abort_busy", busy, 0);
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        #1;
        chk("abort_ready", bus.in_ready, 1);
        chk("abort_col", cursor_col, 0);
        chk("abort_row", cursor_row, 0);
        repeat (5) @(posedge clock);
        #1;
        chk("abort_no_write", bus.wr_en, 0);
        chk("abort_still_idle", busy, 0);

        repeat (3) @(posedge clock);
        chk("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
